// File: rtl/exu_addi_datapath.sv
// Execute-stage datapath for the single-cycle RV64 core: register file, ADDI adder,
// opcode-keyed write-back muxes and sequential next PC. Optional trace: EXU_TRACE_EN.

module exu_key_mux #(
  parameter int NR_KEY   = 1,
  parameter int KEY_LEN  = 10,
  parameter int DATA_LEN = 64
) (
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic [DATA_LEN-1:0]                   out
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic hit;

  // Each lut entry is {key, data}; entry 0 sits in the low bits and wins ties.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    out = '0;
    hit = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!hit && lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_LEN +: DATA_LEN];
        hit = 1'b1;
      end
    end
  end
endmodule

module exu_addi_datapath #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] imm_I,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [9:0]            opcode,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] dnpc,
  output logic [DATA_WIDTH-1:0] src1,
  output logic [DATA_WIDTH-1:0] src2,
  input  logic [ADDR_WIDTH-1:0] dbg_raddr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);
  localparam int          NREG     = 1 << ADDR_WIDTH;
  localparam logic [9:0]  OP_ADDI  = 10'b00_0000_0001;

  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [DATA_WIDTH-1:0] sum0;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wen;

  assign sum0 = imm_I + src1;
  assign dnpc = pc + DATA_WIDTH'(4);

  exu_key_mux #(.NR_KEY(1), .KEY_LEN(10), .DATA_LEN(1)) u_wen_mux (
    .key (opcode),
    .lut ({OP_ADDI, 1'b1}),
    .out (wen)
  );

  exu_key_mux #(.NR_KEY(1), .KEY_LEN(10), .DATA_LEN(DATA_WIDTH)) u_wdata_mux (
    .key (opcode),
    .lut ({OP_ADDI, sum0}),
    .out (wdata)
  );

  // NOTE: the whole file is cleared by the async reset, so this array maps to flops, not a RAM macro.
  // NOTE: sequential state is assigned with <= so every entry samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wen && rd != '0) begin
      rf[rd] <= wdata;
    end
  end

  // x0 is hardwired to zero; reads are also forced to zero while reset is held.
  assign src1      = (rst || rs1 == '0)       ? '0 : rf[rs1];
  assign src2      = (rst || rs2 == '0)       ? '0 : rf[rs2];
  assign dbg_rdata = (rst || dbg_raddr == '0) ? '0 : rf[dbg_raddr];

`ifdef EXU_TRACE_EN
  always @(posedge clk) begin
    $display("%0d,%0d,%0d", rd, rs1, imm_I);
  end
`else
`endif
endmodule

// File: tb/tb_exu_addi_datapath.sv
// Scoreboard bench for exu_addi_datapath: stimulus queues expected values,
// a monitor process pops and compares them on each sample strobe.
`timescale 1ns/1ps

module tb_exu_addi_datapath;
  typedef enum int {K_DBG, K_DNPC, K_WEN, K_WDATA, K_SRC1, K_SRC2} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [63:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] imm_I = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, dbg_raddr = '0;
  logic [9:0]  opcode = '0;
  logic [63:0] pc = '0;
  logic [63:0] dnpc, src1, src2, dbg_rdata;

  exp_t q[$];
  event smp;
  int   checks = 0;
  int   errors = 0;

  exu_addi_datapath dut (
    .clk(clk), .rst(rst), .imm_I(imm_I), .rd(rd), .rs1(rs1), .rs2(rs2),
    .opcode(opcode), .pc(pc), .dnpc(dnpc), .src1(src1), .src2(src2),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #10 if (clk_en) clk = ~clk;

  // Monitor: consumes every queued expectation when the stimulus strobes a sample.
  initial begin
    forever begin
      @(smp);
      while (q.size() > 0) begin
        exp_t        e;
        logic [63:0] act;
        e = q.pop_front();
        case (e.kind)
          K_DBG:   act = dbg_rdata;
          K_DNPC:  act = dnpc;
          K_WEN:   act = {63'd0, dut.wen};
          K_WDATA: act = dut.wdata;
          K_SRC1:  act = src1;
          default: act = src2;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_v(input string name, input kind_e kind, input logic [63:0] val);
    q.push_back('{name, kind, val});
  endtask

  task automatic sample();
    #1 -> smp;
    #1;
  endtask

  task automatic check_reg(input string name, input logic [4:0] idx, input logic [63:0] val);
    dbg_raddr = idx;
    expect_v(name, K_DBG, val);
    sample();
  endtask

  task automatic setup(input logic [9:0] op, input logic [4:0] s1, input logic [4:0] d,
                       input logic [63:0] imm);
    @(negedge clk);
    opcode = op; rs1 = s1; rd = d; imm_I = imm;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset pulse with the clock stopped: every entry must read zero.
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    #3;
    for (int i = 0; i < 32; i++) check_reg($sformatf("reset_x%0d", i), 5'(i), 64'd0);

    clk_en = 1'b1;

    setup(10'b1, 5'd0, 5'd1, 64'd5);
    edge_();
    check_reg("addi_x1", 5'd1, 64'd5);

    // Pre-edge: src1 sees x1, x2 not yet written (no bypass).
    setup(10'b1, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    dbg_raddr = 5'd2;
    expect_v("src1_x1", K_SRC1, 64'd5);
    expect_v("x2_pre_edge", K_DBG, 64'd0);
    expect_v("wdata_addi", K_WDATA, 64'd4);
    sample();
    edge_();
    check_reg("addi_x2_neg1", 5'd2, 64'd4);

    setup(10'b1, 5'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    edge_();
    check_reg("x3_all_ones", 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    setup(10'b1, 5'd3, 5'd3, 64'd1);
    edge_();
    check_reg("x3_wrap", 5'd3, 64'd0);

    setup(10'b1, 5'd0, 5'd0, 64'd7);
    edge_();
    check_reg("x0_protect", 5'd0, 64'd0);
    expect_v("src1_x0", K_SRC1, 64'd0);
    sample();

    // Non-matching opcodes write nothing and both mux outputs are zero.
    setup(10'b10, 5'd1, 5'd4, 64'd9);
    expect_v("wen_nomatch", K_WEN, 64'd0);
    expect_v("wdata_nomatch", K_WDATA, 64'd0);
    sample();
    edge_();
    check_reg("x4_nomatch", 5'd4, 64'd0);
    setup(10'b11, 5'd1, 5'd5, 64'd9);
    expect_v("wen_multihot", K_WEN, 64'd0);
    sample();
    edge_();
    check_reg("x5_multihot", 5'd5, 64'd0);
    setup(10'b0, 5'd1, 5'd5, 64'd9);
    edge_();
    check_reg("x5_op_zero", 5'd5, 64'd0);

    pc = 64'h8000_0000;
    expect_v("dnpc_base", K_DNPC, 64'h8000_0004);
    sample();
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    expect_v("dnpc_wrap", K_DNPC, 64'd0);
    sample();

    rs2 = 5'd1;
    expect_v("src2_x1", K_SRC2, 64'd5);
    sample();

    // Async reset between edges clears the file before the next edge.
    @(negedge clk);
    rst = 1'b1;
    check_reg("x1_async_rst", 5'd1, 64'd0);
    check_reg("x2_async_rst", 5'd2, 64'd0);
    expect_v("src2_in_rst", K_SRC2, 64'd0);
    sample();
    opcode = 10'b1; rs1 = 5'd0; rd = 5'd6; imm_I = 64'd11;
    edge_();
    check_reg("x6_write_in_rst", 5'd6, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    edge_();
    check_reg("x6_after_rst", 5'd6, 64'd11);
    check_reg("x1_after_rst", 5'd1, 64'd0);

    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end
endmodule
